// File: rtl/cr_iu_vec_pcgen_pkg.sv
// Shared IU definitions for the vector PC generator: FSM state encodings
// and datapath widths used by the vector fetch and redirect logic.
package cr_iu_vec_pcgen_pkg;

  localparam int unsigned PC_W = 31;
  localparam int unsigned ID_W = 12;

  typedef enum logic [1:0] {
    P_IDLE = 2'b00,
    P_PEND = 2'b01,
    P_RST  = 2'b10
  } pcgen_state_e;

endpackage

// File: rtl/cr_iu_vec_addr_gen.sv
// Vector table entry address: VBR base plus 4 bytes per interrupt id.
// The sum wraps modulo 2^32; there is deliberately no carry out.
module cr_iu_vec_addr_gen
  import cr_iu_vec_pcgen_pkg::*;
(
  input  logic [PC_W-1:0] vbr_buf,
  input  logic [ID_W-1:0] id_buf,
  output logic [31:0]     ibus_addr
);

  assign ibus_addr = {vbr_buf, 1'b0} + {18'b0, id_buf, 2'b00};

endmodule

// File: rtl/cr_iu_vec_pcgen.sv
// Vector PC generator: fetches the vector table entry and issues the
// resulting redirect (or the reset PC) to the IFU, holding it until granted.
module cr_iu_vec_pcgen
  import cr_iu_vec_pcgen_pkg::*;
(
  input  logic            misc_clk,
  input  logic            cpurst_b,
  input  logic            vector_pcgen_buf_vbr,
  input  logic [PC_W-1:0] vector_pcgen_enter_addr,
  input  logic            vector_pcgen_ibus_req,
  input  logic            vector_pcgen_cur_pc_vld,
  input  logic            vector_pcgen_chgflw_vld,
  input  logic            vector_pcgen_reset_vld,
  input  logic            retire_pcgen_expt_vld,
  input  logic [ID_W-1:0] retire_pcgen_int_id,
  input  logic [31:0]     pad_cpu_rst_addr,
  input  logic [31:0]     bmu_xx_ibus_rdata,
  input  logic            ifu_pcgen_chgflw_grnt,
  output logic            pcgen_bmu_ibus_req,
  output logic [31:0]     pcgen_bmu_ibus_addr,
  output logic            pcgen_ifu_chgflw_vld,
  output logic [PC_W-1:0] pcgen_ifu_chgflw_pc,
  output logic            pcgen_vector_expt_taken
);

  pcgen_state_e    state, state_nxt;
  logic [PC_W-1:0] target, target_nxt;
  logic [PC_W-1:0] vbr_buf;
  logic [ID_W-1:0] id_buf;
  logic [PC_W-1:0] redirect_pc;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge misc_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vbr_buf <= '0;
      id_buf  <= '0;
    end else begin
      if (vector_pcgen_buf_vbr)  vbr_buf <= vector_pcgen_enter_addr;
      if (retire_pcgen_expt_vld) id_buf  <= retire_pcgen_int_id;
    end
  end

  cr_iu_vec_addr_gen u_addr_gen (
    .vbr_buf   (vbr_buf),
    .id_buf    (id_buf),
    .ibus_addr (pcgen_bmu_ibus_addr)
  );

  assign pcgen_bmu_ibus_req = vector_pcgen_ibus_req;

  // Non-vectored redirects bypass vbr_buf so buf_vbr and chgflw_vld may coincide.
  assign redirect_pc = vector_pcgen_cur_pc_vld ? bmu_xx_ibus_rdata[31:1]
                                               : vector_pcgen_enter_addr;

  // NOTE: defaults assigned first so no path through the case infers a latch.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    case (state)
      P_RST: begin
        if (!vector_pcgen_reset_vld) begin
          state_nxt  = P_PEND;
          target_nxt = pad_cpu_rst_addr[31:1];
        end
      end
      P_IDLE: begin
        if (vector_pcgen_chgflw_vld) begin
          state_nxt  = P_PEND;
          target_nxt = redirect_pc;
        end
      end
      P_PEND: begin
        if (vector_pcgen_chgflw_vld) begin
          target_nxt = redirect_pc;
        end else if (ifu_pcgen_chgflw_grnt) begin
          state_nxt = P_IDLE;
        end
      end
      default: state_nxt = P_RST;
    endcase
    if (vector_pcgen_reset_vld) state_nxt = P_RST;
  end

  always_ff @(posedge misc_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state  <= P_RST;
      target <= '0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
    end
  end

  // All outputs below decode registered state only, so no comb loop with the vector FSM.
  assign pcgen_ifu_chgflw_vld    = (state == P_PEND);
  assign pcgen_ifu_chgflw_pc     = target;
  assign pcgen_vector_expt_taken = (state == P_IDLE);

endmodule

// File: tb/tb_cr_iu_vec_pcgen.sv
// Directed self-checking bench for cr_iu_vec_pcgen: reset exit, vectored and
// non-vectored redirects, address wrap, overwrite and mid-pend reset.
module tb_cr_iu_vec_pcgen;

  logic        misc_clk;
  logic        cpurst_b;
  logic        vector_pcgen_buf_vbr;
  logic [30:0] vector_pcgen_enter_addr;
  logic        vector_pcgen_ibus_req;
  logic        vector_pcgen_cur_pc_vld;
  logic        vector_pcgen_chgflw_vld;
  logic        vector_pcgen_reset_vld;
  logic        retire_pcgen_expt_vld;
  logic [11:0] retire_pcgen_int_id;
  logic [31:0] pad_cpu_rst_addr;
  logic [31:0] bmu_xx_ibus_rdata;
  logic        ifu_pcgen_chgflw_grnt;
  logic        pcgen_bmu_ibus_req;
  logic [31:0] pcgen_bmu_ibus_addr;
  logic        pcgen_ifu_chgflw_vld;
  logic [30:0] pcgen_ifu_chgflw_pc;
  logic        pcgen_vector_expt_taken;

  int tests_run = 0;
  int tests_failed = 0;

  cr_iu_vec_pcgen dut (
    .misc_clk                (misc_clk),
    .cpurst_b                (cpurst_b),
    .vector_pcgen_buf_vbr    (vector_pcgen_buf_vbr),
    .vector_pcgen_enter_addr (vector_pcgen_enter_addr),
    .vector_pcgen_ibus_req   (vector_pcgen_ibus_req),
    .vector_pcgen_cur_pc_vld (vector_pcgen_cur_pc_vld),
    .vector_pcgen_chgflw_vld (vector_pcgen_chgflw_vld),
    .vector_pcgen_reset_vld  (vector_pcgen_reset_vld),
    .retire_pcgen_expt_vld   (retire_pcgen_expt_vld),
    .retire_pcgen_int_id     (retire_pcgen_int_id),
    .pad_cpu_rst_addr        (pad_cpu_rst_addr),
    .bmu_xx_ibus_rdata       (bmu_xx_ibus_rdata),
    .ifu_pcgen_chgflw_grnt   (ifu_pcgen_chgflw_grnt),
    .pcgen_bmu_ibus_req      (pcgen_bmu_ibus_req),
    .pcgen_bmu_ibus_addr     (pcgen_bmu_ibus_addr),
    .pcgen_ifu_chgflw_vld    (pcgen_ifu_chgflw_vld),
    .pcgen_ifu_chgflw_pc     (pcgen_ifu_chgflw_pc),
    .pcgen_vector_expt_taken (pcgen_vector_expt_taken)
  );

  initial misc_clk = 1'b0;
  always #5 misc_clk = ~misc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge misc_clk);
    #1;
  endtask

  task automatic check_pend(input string tag, input logic [30:0] pc);
    check({tag, "_vld"},   {31'b0, pcgen_ifu_chgflw_vld}, 32'h1);
    check({tag, "_pc"},    {1'b0, pcgen_ifu_chgflw_pc}, {1'b0, pc});
    check({tag, "_taken"}, {31'b0, pcgen_vector_expt_taken}, 32'h0);
  endtask

  task automatic grant_to_idle(input string tag);
    ifu_pcgen_chgflw_grnt = 1'b1;
    step();
    ifu_pcgen_chgflw_grnt = 1'b0;
    check({tag, "_idle_vld"},   {31'b0, pcgen_ifu_chgflw_vld}, 32'h0);
    check({tag, "_idle_taken"}, {31'b0, pcgen_vector_expt_taken}, 32'h1);
  endtask

  task automatic redirect(input logic [30:0] enter, input logic cur_pc, input logic [31:0] rdata);
    vector_pcgen_enter_addr = enter;
    vector_pcgen_cur_pc_vld = cur_pc;
    bmu_xx_ibus_rdata       = rdata;
    vector_pcgen_chgflw_vld = 1'b1;
    step();
    vector_pcgen_chgflw_vld = 1'b0;
    vector_pcgen_cur_pc_vld = 1'b0;
  endtask

  initial begin
    cpurst_b                = 1'b0;
    vector_pcgen_buf_vbr    = 1'b0;
    vector_pcgen_enter_addr = '0;
    vector_pcgen_ibus_req   = 1'b0;
    vector_pcgen_cur_pc_vld = 1'b0;
    vector_pcgen_chgflw_vld = 1'b0;
    vector_pcgen_reset_vld  = 1'b1;
    retire_pcgen_expt_vld   = 1'b0;
    retire_pcgen_int_id     = '0;
    pad_cpu_rst_addr        = 32'h0000_1000;
    bmu_xx_ibus_rdata       = '0;
    ifu_pcgen_chgflw_grnt   = 1'b0;

    // Reset values
    step();
    step();
    check("rst_vld",   {31'b0, pcgen_ifu_chgflw_vld}, 32'h0);
    check("rst_pc",    {1'b0, pcgen_ifu_chgflw_pc}, 32'h0);
    check("rst_taken", {31'b0, pcgen_vector_expt_taken}, 32'h0);
    check("rst_addr",  pcgen_bmu_ibus_addr, 32'h0);
    check("rst_req",   {31'b0, pcgen_bmu_ibus_req}, 32'h0);

    cpurst_b = 1'b1;
    step();
    step();
    check("prst_hold_vld",   {31'b0, pcgen_ifu_chgflw_vld}, 32'h0);
    check("prst_hold_taken", {31'b0, pcgen_vector_expt_taken}, 32'h0);

    // Reset exit: reset PC issued, held until grant
    vector_pcgen_reset_vld = 1'b0;
    step();
    check_pend("rexit", 31'h0000_0800);
    step();
    check_pend("rexit_hold", 31'h0000_0800);
    grant_to_idle("rexit");

    // Vectored interrupt: table address then redirect from fetched entry
    retire_pcgen_int_id     = 12'd5;
    retire_pcgen_expt_vld   = 1'b1;
    vector_pcgen_enter_addr = 31'h4000_0000;
    vector_pcgen_buf_vbr    = 1'b1;
    vector_pcgen_ibus_req   = 1'b1;
    step();
    retire_pcgen_expt_vld   = 1'b0;
    vector_pcgen_buf_vbr    = 1'b0;
    retire_pcgen_int_id     = 12'h7AB;
    vector_pcgen_enter_addr = 31'h0000_0AAA;
    #1;
    check("vec_req",  {31'b0, pcgen_bmu_ibus_req}, 32'h1);
    check("vec_addr", pcgen_bmu_ibus_addr, 32'h8000_0014);
    vector_pcgen_ibus_req = 1'b0;
    #1;
    check("vec_req_off", {31'b0, pcgen_bmu_ibus_req}, 32'h0);
    redirect(31'h0000_0AAA, 1'b1, 32'h0000_2001);
    check_pend("vec", 31'h0000_1000);
    grant_to_idle("vec");

    // Non-vectored: buf_vbr and chgflw_vld together, target bypassed
    vector_pcgen_buf_vbr = 1'b1;
    redirect(31'h0000_1234, 1'b0, 32'hFFFF_FFFF);
    vector_pcgen_buf_vbr = 1'b0;
    check_pend("nvec", 31'h0000_1234);
    check("nvec_vbr_addr", pcgen_bmu_ibus_addr, 32'h0000_247C);
    grant_to_idle("nvec");

    // Address wrap
    vector_pcgen_enter_addr = 31'h7FFF_FFFE;
    vector_pcgen_buf_vbr    = 1'b1;
    retire_pcgen_int_id     = 12'hFFF;
    retire_pcgen_expt_vld   = 1'b1;
    step();
    vector_pcgen_buf_vbr  = 1'b0;
    retire_pcgen_expt_vld = 1'b0;
    check("wrap_addr", pcgen_bmu_ibus_addr, 32'h0000_3FF8);

    // Overwrite while pending, then newest wins over a same-cycle grant
    redirect(31'h0000_0A0A, 1'b0, 32'h0);
    check_pend("ovw_a", 31'h0000_0A0A);
    redirect(31'h0000_0B0B, 1'b0, 32'h0);
    check_pend("ovw_b", 31'h0000_0B0B);
    ifu_pcgen_chgflw_grnt = 1'b1;
    redirect(31'h0000_0C0C, 1'b0, 32'h0);
    ifu_pcgen_chgflw_grnt = 1'b0;
    check_pend("ovw_grnt", 31'h0000_0C0C);

    // Mid-pend reset drops the redirect, then re-exits with the new reset PC
    vector_pcgen_reset_vld = 1'b1;
    step();
    check("mrst_vld",   {31'b0, pcgen_ifu_chgflw_vld}, 32'h0);
    check("mrst_taken", {31'b0, pcgen_vector_expt_taken}, 32'h0);
    pad_cpu_rst_addr       = 32'h2000_0003;
    vector_pcgen_reset_vld = 1'b0;
    step();
    check_pend("mrst_exit", 31'h1000_0001);

    // Asynchronous reset takes effect without a clock edge
    #2;
    cpurst_b = 1'b0;
    #1;
    check("arst_vld",  {31'b0, pcgen_ifu_chgflw_vld}, 32'h0);
    check("arst_pc",   {1'b0, pcgen_ifu_chgflw_pc}, 32'h0);
    check("arst_addr", pcgen_bmu_ibus_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
